// File: rtl/regfile_seq_ctrl_if.sv
// Memory-side bus of the RV32I sequencer: instruction register contents in,
// request/write/address-select out, single-cycle completion pulse back.
interface regfile_seq_ctrl_if;
  logic [31:0] instr_i;
  logic        mem_ack_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_addr_sel_o;

  modport master (
    input  instr_i,
    input  mem_ack_i,
    output mem_req_o,
    output mem_we_o,
    output mem_addr_sel_o
  );

  modport slave (
    output instr_i,
    output mem_ack_i,
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_sel_o
  );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// write-back for one instruction at a time and drives the datapath strobes.
module regfile_seq_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_seq_ctrl_if.master         bus,
  input  logic                       branch_taken_i,
  output logic                       ir_we_o,
  output logic                       ab_we_o,
  output logic                       pc_we_o,
  output logic                       pc_sel_o,
  output logic                       alu_a_sel_o,
  output logic                       alu_b_sel_o,
  output logic [4:0]                 rs1_addr_o,
  output logic [4:0]                 rs2_addr_o,
  output logic [4:0]                 rd_addr_o,
  output logic                       reg_wr_en_o,
  output logic [1:0]                 wb_sel_o,
  output logic [2:0]                 state_o,
  output logic                       halt_o,
  output logic [31:0]                instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_BAD
  } cls_t;

  function automatic cls_t decode_op(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_IALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b0110111: return C_LUI;
      default:    return C_BAD;
    endcase
  endfunction

  state_t      state;
  cls_t        cls;
  cls_t        dec_cls;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        retire;

  assign rs1_addr_o = bus.instr_i[19:15];
  assign rs2_addr_o = bus.instr_i[24:20];
  assign rd_addr_o  = bus.instr_i[11:7];
  assign state_o    = state;
  assign halt_o     = (state == S_HALT);
  assign dec_cls    = decode_op(bus.instr_i[6:0]);

  // The last tolerated waiting cycle is the one where the count reaches MEM_TIMEOUT-1;
  // an ack arriving in that same cycle still completes the access.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_cnt == MEM_TIMEOUT - 1);

  // Strobes decode from state (plus ack/branch where the datapath needs it) and are
  // masked during rst, since the state register only reloads at the end of that cycle.
  always_comb begin
    bus.mem_req_o      = 1'b0;
    bus.mem_we_o       = 1'b0;
    bus.mem_addr_sel_o = 1'b0;
    ir_we_o            = 1'b0;
    ab_we_o            = 1'b0;
    pc_we_o            = 1'b0;
    pc_sel_o           = 1'b0;
    alu_a_sel_o        = 1'b0;
    alu_b_sel_o        = 1'b0;
    reg_wr_en_o        = 1'b0;
    wb_sel_o           = 2'd0;
    retire             = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_req_o = 1'b1;
          ir_we_o       = bus.mem_ack_i;
        end
        S_DECODE: ab_we_o = 1'b1;
        S_EXEC: begin
          case (cls)
            C_IALU, C_LOAD, C_STORE: alu_b_sel_o = 1'b1;
            C_BRANCH: begin
              alu_a_sel_o = 1'b1;
              alu_b_sel_o = 1'b1;
              pc_we_o     = 1'b1;
              pc_sel_o    = branch_taken_i;
              retire      = 1'b1;
            end
            C_JAL: begin
              alu_a_sel_o = 1'b1;
              alu_b_sel_o = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req_o      = 1'b1;
          bus.mem_addr_sel_o = 1'b1;
          bus.mem_we_o       = (cls == C_STORE);
          if (bus.mem_ack_i && cls == C_STORE) begin
            pc_we_o = 1'b1;
            retire  = 1'b1;
          end
        end
        S_WB: begin
          reg_wr_en_o = 1'b1;
          pc_we_o     = 1'b1;
          retire      = 1'b1;
          case (cls)
            C_LOAD: wb_sel_o = 2'd1;
            C_JAL: begin
              wb_sel_o    = 2'd2;
              pc_sel_o    = 1'b1;
              alu_a_sel_o = 1'b1;
              alu_b_sel_o = 1'b1;
            end
            C_LUI:   wb_sel_o = 2'd3;
            default: wb_sel_o = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= state_t'(RESET_STATE);
      instret_o <= 32'd0;
      tmo_cnt   <= 32'd0;
    end else begin
      if (retire) instret_o <= instret_o + 32'd1;
      case (state)
        S_FETCH: begin
          if (bus.mem_ack_i)  state <= S_DECODE;
          else if (tmo_hit)   state <= S_HALT;
          else                tmo_cnt <= tmo_cnt + 32'd1;
        end
        S_DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            C_LUI:   state <= S_WB;
            C_BAD:   state <= S_HALT;
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_BRANCH: begin
              state   <= S_FETCH;
              tmo_cnt <= 32'd0;
            end
            C_LOAD, C_STORE: begin
              state   <= S_MEM;
              tmo_cnt <= 32'd0;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack_i) begin
            if (cls == C_STORE) begin
              state   <= S_FETCH;
              tmo_cnt <= 32'd0;
            end else begin
              state <= S_WB;
            end
          end else if (tmo_hit) begin
            state <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          tmo_cnt <= 32'd0;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
